// File: rtl/button_event_poller.sv
// Avalon-MM master that polls a button PIO edge-capture register, clears the bits it read,
// and hands each non-zero capture to a valid/ready consumer. Optional macro: BUTTON_EVENT_POLLER_LEVEL_READ_EN.
module button_event_poller #(
  parameter int DATA_WIDTH  = 4,
  parameter int POLL_PERIOD = 1000,
  parameter int EDGE_ADDR   = 3,
  parameter int LEVEL_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [DATA_WIDTH-1:0] event_mask,
  output logic [DATA_WIDTH-1:0] btn_level
);

  localparam int              CNT_W  = $clog2(POLL_PERIOD + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_PERIOD - 1);
  localparam logic [1:0]      EDGE_A = 2'(EDGE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_EDGE,
    S_WAIT_EDGE,
    S_CLEAR,
`ifdef BUTTON_EVENT_POLLER_LEVEL_READ_EN
    S_READ_LEVEL,
    S_WAIT_LEVEL,
`endif
    S_EMIT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;

  // Upper readdata bits are don't-care for a narrow PIO.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= RELOAD;
      cap_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (enable) begin
          state_d = S_READ_EDGE;
        end
      end
      S_READ_EDGE: state_d = S_WAIT_EDGE;
      S_WAIT_EDGE: begin
        cap_d = avm_readdata[DATA_WIDTH-1:0];
        if (cap_d == '0) begin
          state_d = S_IDLE;
          cnt_d   = RELOAD;
        end else begin
          state_d = S_CLEAR;
        end
      end
`ifdef BUTTON_EVENT_POLLER_LEVEL_READ_EN
      S_CLEAR:      state_d = S_READ_LEVEL;
      S_READ_LEVEL: state_d = S_WAIT_LEVEL;
      S_WAIT_LEVEL: begin
        state_d = S_EMIT;
        mask_d  = cap_q;
      end
`else
      S_CLEAR: begin
        state_d = S_EMIT;
        mask_d  = cap_q;
      end
`endif
      S_EMIT: begin
        if (event_ready) begin
          state_d = S_IDLE;
          cnt_d   = RELOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = RELOAD;
      end
    endcase
  end

  // Bus outputs are a pure decode of registered state so no input reaches an output.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'b00;
    avm_writedata  = 32'h0;
    case (state_q)
      S_READ_EDGE: begin
        avm_chipselect = 1'b1;
        avm_address    = EDGE_A;
      end
      S_CLEAR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = EDGE_A;
        avm_writedata  = 32'(cap_q);
      end
`ifdef BUTTON_EVENT_POLLER_LEVEL_READ_EN
      S_READ_LEVEL: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'(LEVEL_ADDR);
      end
`endif
      default: ;
    endcase
  end

  assign event_valid = (state_q == S_EMIT);
  assign event_mask  = mask_q;

`ifdef BUTTON_EVENT_POLLER_LEVEL_READ_EN
  logic [DATA_WIDTH-1:0] level_q, level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  always_comb begin
    level_d = level_q;
    if (state_q == S_WAIT_LEVEL) begin
      level_d = avm_readdata[DATA_WIDTH-1:0];
    end
  end

  assign btn_level = level_q;
`else
  assign btn_level = '0;
`endif

endmodule
